// File: rtl/spi_pkg.sv
// Purpose : shared types and constants for the SPI mode-0 target.
// Latency : n/a (declarations only).
// Backpres: n/a.
package spi_pkg;

   localparam int BYTE_W = 8;
   localparam int CNT_W  = 3;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_t;

   // Synchroniser reset values match the idle bus so that reset release
   // never looks like an SCK or CS edge.
   localparam logic SCK_RST  = 1'b0;
   localparam logic CS_N_RST = 1'b1;
   localparam logic MOSI_RST = 1'b0;

endpackage

// File: rtl/sync_ff.sv
// Purpose : multi-flop synchroniser for a single asynchronous bit.
// Latency : STAGES clk cycles from d to q.
// Backpres: none (free-running).
// Ports   : clk, rst_n (async active-low), d (async input), q (synchronised).
module sync_ff #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe <= {STAGES{RESET_VAL}};
      end else begin
         pipe <= {pipe[STAGES-2:0], d};
      end
   end

   assign q = pipe[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// Purpose : SPI mode-0 target; received bytes pulse out on rx_valid_o, tx_byte_i shifted out on MISO.
// Latency : pin edge -> strobe after SYNC_STAGES cycles, outputs one cycle later (SYNC_STAGES+1 total).
// Backpres: none; the SPI controller sets the pace, tx_byte_i is sampled at each byte boundary.
// Ports   : clk_i/rst_ni; spi_sck_i, spi_cs_ni, spi_mosi_i, spi_miso_o (board pins);
//           tx_byte_i (next byte to send); rx_valid_o/rx_byte_o (received byte);
//           frame_start_o (CS fall pulse), frame_active_o (CS low, synchronised).
module spi_peripheral
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              spi_sck_i,
   input  logic              spi_cs_ni,
   input  logic              spi_mosi_i,
   output logic              spi_miso_o,
   input  logic [BYTE_W-1:0] tx_byte_i,
   output logic              rx_valid_o,
   output logic [BYTE_W-1:0] rx_byte_o,
   output logic              frame_start_o,
   output logic              frame_active_o
);

   logic sck_sync, cs_n_sync, mosi_sync;
   logic sck_q, cs_n_q;
   logic sck_rise, sck_fall, cs_rise, cs_fall;

   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(SCK_RST)) u_sync_sck (
      .clk(clk_i), .rst_n(rst_ni), .d(spi_sck_i), .q(sck_sync)
   );
   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(CS_N_RST)) u_sync_cs (
      .clk(clk_i), .rst_n(rst_ni), .d(spi_cs_ni), .q(cs_n_sync)
   );
   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(MOSI_RST)) u_sync_mosi (
      .clk(clk_i), .rst_n(rst_ni), .d(spi_mosi_i), .q(mosi_sync)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sck_q  <= SCK_RST;
         cs_n_q <= CS_N_RST;
      end else begin
         sck_q  <= sck_sync;
         cs_n_q <= cs_n_sync;
      end
   end

   assign sck_rise = sck_sync & ~sck_q;
   assign sck_fall = ~sck_sync & sck_q;
   assign cs_fall  = ~cs_n_sync & cs_n_q;
   assign cs_rise  = cs_n_sync & ~cs_n_q;

   spi_state_t        state, state_d;
   logic [CNT_W-1:0]  bit_cnt, bit_cnt_d;
   logic [BYTE_W-1:0] rx_shift, rx_shift_d;
   logic [BYTE_W-1:0] tx_shift, tx_shift_d;
   logic [BYTE_W-1:0] rx_byte_q, rx_byte_d;
   logic              miso_q, miso_d;
   logic              rx_valid_q, rx_valid_d;
   logic              frame_start_q, frame_start_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         rx_shift      <= '0;
         tx_shift      <= '0;
         rx_byte_q     <= '0;
         miso_q        <= 1'b0;
         rx_valid_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state         <= state_d;
         bit_cnt       <= bit_cnt_d;
         rx_shift      <= rx_shift_d;
         tx_shift      <= tx_shift_d;
         rx_byte_q     <= rx_byte_d;
         miso_q        <= miso_d;
         rx_valid_q    <= rx_valid_d;
         frame_start_q <= frame_start_d;
      end
   end

   always_comb begin
      state_d       = state;
      bit_cnt_d     = bit_cnt;
      rx_shift_d    = rx_shift;
      tx_shift_d    = tx_shift;
      rx_byte_d     = rx_byte_q;
      miso_d        = miso_q;
      rx_valid_d    = 1'b0;
      frame_start_d = 1'b0;

      case (state)
         IDLE: begin
            bit_cnt_d = '0;
            miso_d    = 1'b0;
            // SCK edges are ignored here, including one coincident with CS fall.
            if (cs_fall) begin
               state_d       = ACTIVE;
               tx_shift_d    = tx_byte_i;
               miso_d        = tx_byte_i[BYTE_W-1];
               frame_start_d = 1'b1;
            end
         end
         ACTIVE: begin
            // CS release takes priority over any SCK edge in the same cycle.
            if (cs_rise) begin
               state_d    = IDLE;
               bit_cnt_d  = '0;
               miso_d     = 1'b0;
               rx_shift_d = '0;
               tx_shift_d = '0;
            end else if (sck_rise) begin
               rx_shift_d = {rx_shift[BYTE_W-2:0], mosi_sync};
               bit_cnt_d  = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  rx_byte_d  = {rx_shift[BYTE_W-2:0], mosi_sync};
                  rx_valid_d = 1'b1;
               end
            end else if (sck_fall) begin
               // At a byte boundary the next tx byte is fetched; this leaves the
               // consumer half an SCK period after rx_valid_o to update tx_byte_i.
               if (bit_cnt != '0) begin
                  tx_shift_d = {tx_shift[BYTE_W-2:0], 1'b0};
                  miso_d     = tx_shift[BYTE_W-2];
               end else begin
                  tx_shift_d = tx_byte_i;
                  miso_d     = tx_byte_i[BYTE_W-1];
               end
            end
         end
      endcase
   end

   assign spi_miso_o     = miso_q;
   assign rx_valid_o     = rx_valid_q;
   assign rx_byte_o      = rx_byte_q;
   assign frame_start_o  = frame_start_q;
   assign frame_active_o = (state == ACTIVE);

endmodule
